// File: rtl/binomial_fir_pkg.sv
// Shared constants and helpers for the binomial smoothing FIR.
// Coefficients are elaboration-time constants; nothing here produces logic by itself.
package binomial_fir_pkg;

    typedef enum logic [1:0] {
        RND_FLOOR      = 2'd0,
        RND_HALF_UP    = 2'd1,
        RND_CONVERGENT = 2'd2
    } rnd_mode_e;

    function automatic int unsigned binom(input int unsigned n, input int unsigned k);
        int unsigned r;
        r = 1;
        // C(n,i+1) = C(n,i)*(n-i)/(i+1) stays an exact integer at every step
        for (int unsigned i = 0; i < k; i++) begin
            r = r * (n - i) / (i + 1);
        end
        return r;
    endfunction

    function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned order);
        return data_w + order;
    endfunction

endpackage

// File: rtl/binomial_fir_lane.sv
// One lane of the binomial FIR: delay line feeding a 3-stage term/sum/scale pipeline.
// Control (shift, clear, advance) is shared across lanes by the top level.
module binomial_fir_lane
    import binomial_fir_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ORDER  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              clr,
    input  logic              shift,
    input  logic [1:0]        rnd_mode,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int TAPS  = ORDER + 1;
    localparam int ACC_W = acc_w(DATA_W, ORDER);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (ORDER - 1);

    function automatic logic signed [ACC_W-1:0] cmul(input logic signed [ACC_W-1:0] x,
                                                     input int unsigned c);
        logic signed [ACC_W-1:0] acc;
        acc = '0;
        for (int unsigned b = 0; b < 32; b++) begin
            if (c[b]) acc = acc + (x <<< b);
        end
        return acc;
    endfunction

    logic [DATA_W-1:0]       tap_q  [TAPS];
    logic [DATA_W-1:0]       tap_d  [TAPS];
    logic signed [ACC_W-1:0] prod   [TAPS];
    logic signed [ACC_W-1:0] term_q [TAPS];
    logic signed [ACC_W-1:0] term_d [TAPS];
    logic signed [ACC_W-1:0] sum_q, sum_d;
    logic [DATA_W-1:0]       dout_q, dout_d;
    logic                    adv;

    assign adv = ce & ~clr;

    for (genvar k = 0; k < TAPS; k++) begin : g_term
        localparam int unsigned COEF = binom(ORDER, k);
        assign prod[k] = cmul({{ORDER{tap_q[k][DATA_W-1]}}, tap_q[k]}, COEF);
    end

    // A clear edge freezes term/sum/dout so dout keeps its last value.
    always_comb begin
        tap_d  = tap_q;
        term_d = term_q;
        sum_d  = sum_q;
        dout_d = dout_q;
        if (clr) begin
            for (int unsigned k = 0; k < TAPS; k++) tap_d[k] = '0;
        end else if (shift) begin
            tap_d[0] = din;
            for (int unsigned k = 1; k < TAPS; k++) tap_d[k] = tap_q[k-1];
        end
        if (adv) begin
            for (int unsigned k = 0; k < TAPS; k++) term_d[k] = prod[k];
            sum_d = (rnd_mode == RND_HALF_UP) ? HALF : '0;
            for (int unsigned k = 0; k < TAPS; k++) sum_d = sum_d + term_q[k];
            dout_d = sum_q[ACC_W-1:ORDER];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                tap_q[k]  <= '0;
                term_q[k] <= '0;
            end
            sum_q  <= '0;
            dout_q <= '0;
        end else begin
            tap_q  <= tap_d;
            term_q <= term_d;
            sum_q  <= sum_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/binomial_fir_pipe.sv
// Multi-lane binomial smoothing FIR: shared prime counter and valid pipe,
// NUM_CH identical lane datapaths.
module binomial_fir_pipe
    import binomial_fir_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ORDER  = 2,
    parameter int NUM_CH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic                     clr,
    input  logic                     rnd,
    input  logic                     in_valid,
    input  logic [NUM_CH*DATA_W-1:0] din,
    output logic                     out_valid,
    output logic [NUM_CH*DATA_W-1:0] dout
);

    localparam int TAPS  = ORDER + 1;
    localparam int CNT_W = $clog2(TAPS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TAPS);

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    // vld[0] tracks the delay line, vld[3] the output register
    logic [3:0]       vld_q, vld_d;
    logic             accept;
    logic [1:0]       rnd_mode;

    assign accept   = ce & in_valid & ~clr;
    assign cnt_inc  = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 1'b1;
    assign rnd_mode = rnd ? RND_HALF_UP : RND_FLOOR;

    always_comb begin
        cnt_d = cnt_q;
        vld_d = vld_q;
        if (clr) begin
            cnt_d = '0;
            vld_d = '0;
        end else if (ce) begin
            if (in_valid) cnt_d = cnt_inc;
            vld_d = {vld_q[2:0], in_valid && (cnt_inc == CNT_FULL)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            vld_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            vld_q <= vld_d;
        end
    end

    assign out_valid = vld_q[3];

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
        binomial_fir_lane #(
            .DATA_W (DATA_W),
            .ORDER  (ORDER)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .ce       (ce),
            .clr      (clr),
            .shift    (accept),
            .rnd_mode (rnd_mode),
            .din      (din[ch*DATA_W +: DATA_W]),
            .dout     (dout[ch*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_binomial_fir_pipe.sv
// Directed bench for binomial_fir_pipe: a 4-lane ORDER=2 instance driven from a
// vector table plus hand sequences, and an ORDER=6 instance for full-scale inputs.
module tb_binomial_fir_pipe;

    localparam int DW  = 8;
    localparam int NCH = 4;

    logic              clk = 1'b0;
    logic              rst_n, ce, clr, rnd, in_valid;
    logic [NCH*DW-1:0] din_a, dout_a;
    logic              out_valid_a;
    logic [DW-1:0]     din_b, dout_b;
    logic              out_valid_b;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    binomial_fir_pipe #(.DATA_W(DW), .ORDER(2), .NUM_CH(NCH)) dut_a (
        .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr), .rnd(rnd), .in_valid(in_valid),
        .din(din_a), .out_valid(out_valid_a), .dout(dout_a)
    );

    binomial_fir_pipe #(.DATA_W(DW), .ORDER(6), .NUM_CH(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr), .rnd(rnd), .in_valid(in_valid),
        .din(din_b), .out_valid(out_valid_b), .dout(dout_b)
    );

    typedef struct {
        logic          ce;
        logic          clr;
        logic          rnd;
        logic          iv;
        logic [DW-1:0] d;
        logic          ev;   // expected out_valid after the edge
        logic          ck;   // compare dout on this row
        logic [DW-1:0] ed;   // expected lane-0 dout
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic c, input logic cl, input logic r, input logic iv,
                       input logic [DW-1:0] d, input logic ev, input logic ck,
                       input logic [DW-1:0] ed);
        vecs.push_back('{c, cl, r, iv, d, ev, ck, ed});
    endtask

    // ce=1, clr=0 row
    task automatic a(input logic r, input logic iv, input logic [DW-1:0] d,
                     input logic ev, input logic ck, input logic [DW-1:0] ed);
        add(1'b1, 1'b0, r, iv, d, ev, ck, ed);
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b0; clr = 1'b0; rnd = 1'b0; in_valid = 1'b0;
        din_a = '0; din_b = '0;

        // impulse: accepts 0,0,64 then zeros -> 16,32,16,0 once primed
        a(0,1,8'd0,  0,1,8'd0);   a(0,1,8'd0,  0,1,8'd0);   a(0,1,8'd64, 0,1,8'd0);
        a(0,1,8'd0,  0,1,8'd0);   a(0,1,8'd0,  0,1,8'd0);   a(0,1,8'd0,  1,1,8'd16);
        a(0,1,8'd0,  1,1,8'd32);  a(0,1,8'd0,  1,1,8'd16);  a(0,1,8'd0,  1,1,8'd0);
        // stall: five ce=0 edges with a junk sample that must be ignored
        a(0,1,8'd64, 1,1,8'd0);   a(0,1,8'd0,  1,1,8'd0);   a(0,1,8'd0,  1,1,8'd0);
        a(0,1,8'd0,  1,1,8'd16);
        for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 1'b0, 1'b1, 8'd99, 1'b1, 1'b1, 8'd16);
        a(0,1,8'd0,  1,1,8'd32);  a(0,1,8'd0,  1,1,8'd16);  a(0,1,8'd0,  1,1,8'd0);
        a(0,1,8'd0,  1,1,8'd0);
        // bubbles: in_valid alternates, bubble data must be ignored
        a(0,1,8'd64, 1,1,8'd0);   a(0,0,8'd77, 1,1,8'd0);   a(0,1,8'd0,  1,1,8'd0);
        a(0,0,8'd77, 1,1,8'd16);  a(0,1,8'd0,  0,0,8'd0);   a(0,0,8'd77, 1,1,8'd32);
        a(0,0,8'd77, 0,0,8'd0);   a(0,0,8'd77, 1,1,8'd16);  a(0,0,8'd77, 0,0,8'd0);
        a(0,0,8'd77, 0,0,8'd0);   a(0,0,8'd77, 0,0,8'd0);
        // clear with a simultaneous sample: dout holds, valid drops, 100 discarded
        add(1'b1, 1'b1, 1'b0, 1'b1, 8'd100, 1'b0, 1'b1, 8'd16);
        a(0,1,8'd8,  0,0,8'd0);   a(0,1,8'd0,  0,0,8'd0);   a(0,1,8'd0,  0,0,8'd0);
        a(0,1,8'd0,  0,0,8'd0);   a(0,1,8'd0,  0,0,8'd0);   a(0,1,8'd0,  1,1,8'd2);
        a(0,1,8'd0,  1,1,8'd0);
        // round half-up
        a(1,1,8'd1,  1,1,8'd0);   a(1,1,8'd1,  1,1,8'd0);   a(1,1,8'd0,  1,1,8'd0);
        a(1,1,8'd0,  1,1,8'd0);   a(1,1,8'hFF, 1,1,8'd1);   a(1,1,8'hFF, 1,1,8'd1);
        a(1,1,8'd0,  1,1,8'd0);   a(1,1,8'd0,  1,1,8'd0);   a(1,1,8'd0,  1,1,8'hFF);
        a(1,1,8'd0,  1,1,8'hFF);  a(1,1,8'd0,  1,1,8'd0);   a(1,1,8'd0,  1,1,8'd0);
        // same windows with floor
        a(0,1,8'd1,  1,1,8'd0);   a(0,1,8'd1,  1,1,8'd0);   a(0,1,8'd0,  1,1,8'd0);
        a(0,1,8'd0,  1,1,8'd0);   a(0,1,8'hFF, 1,1,8'd0);   a(0,1,8'hFF, 1,1,8'd0);
        a(0,1,8'd0,  1,1,8'd0);   a(0,1,8'd0,  1,1,8'hFF);  a(0,1,8'd0,  1,1,8'hFF);
        a(0,1,8'd0,  1,1,8'hFF);  a(0,1,8'd0,  1,1,8'hFF);  a(0,1,8'd0,  1,1,8'd0);

        #1;
        chk("reset_valid_a", {31'd0, out_valid_a}, 32'd0);
        chk("reset_dout_a", dout_a, 32'd0);
        chk("reset_valid_b", {31'd0, out_valid_b}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            ce = vecs[i].ce; clr = vecs[i].clr; rnd = vecs[i].rnd; in_valid = vecs[i].iv;
            din_a = '0;
            din_a[DW-1:0] = vecs[i].d;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid_a}, {31'd0, vecs[i].ev});
            if (vecs[i].ck) begin
                chk($sformatf("vec%0d_dout", i), {24'd0, dout_a[DW-1:0]}, {24'd0, vecs[i].ed});
                chk($sformatf("vec%0d_lanes123", i), {8'd0, dout_a[NCH*DW-1:DW]}, 32'd0);
            end
        end

        // multi-lane impulses of distinct amplitude, then an async reset pulse
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        begin
            logic [31:0] ml_exp [2];
            ml_exp[0] = 32'h10F00804;
            ml_exp[1] = 32'h20E01008;
            for (int n = 1; n <= 7; n++) begin
                ce = 1'b1; clr = 1'b0; rnd = 1'b0; in_valid = 1'b1;
                din_a = (n == 3) ? {8'h40, 8'hC0, 8'h20, 8'h10} : '0;
                @(posedge clk); #1;
                if (n == 5) chk("ml_prevalid", {31'd0, out_valid_a}, 32'd0);
                if (n >= 6) begin
                    chk($sformatf("ml_valid_%0d", n), {31'd0, out_valid_a}, 32'd1);
                    chk($sformatf("ml_dout_%0d", n), dout_a, ml_exp[n-6]);
                end
            end
        end
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid_a}, 32'd0);
        chk("async_rst_dout", dout_a, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ORDER=6 full-scale: -128 then 127, round half-up, no wrap
        for (int n = 1; n <= 20; n++) begin
            ce = 1'b1; clr = 1'b0; rnd = 1'b1; in_valid = 1'b1;
            din_a = '0;
            din_b = (n <= 10) ? 8'h80 : 8'h7F;
            @(posedge clk); #1;
            if (n == 9) chk("ext_prevalid", {31'd0, out_valid_b}, 32'd0);
            if (n == 10 || n == 20) chk($sformatf("ext_valid_%0d", n), {31'd0, out_valid_b}, 32'd1);
            if (n == 10) chk("ext_min", {24'd0, dout_b}, 32'h80);
            if (n == 20) chk("ext_max", {24'd0, dout_b}, 32'h7F);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
